// File: rtl/ram_fifo_pkg.sv
// Shared constants and helpers for the RAM-backed valid/ready FIFO.
// ENABLE/DISABLE select the RAM output-register mode.
`ifndef ENABLE
`define ENABLE 1'b1
`endif
`ifndef DISABLE
`define DISABLE 1'b0
`endif

package ram_fifo_pkg;

  localparam int SKID_DEPTH = 2;

  // Occupancy from free-running pointers of ptr_w bits (wraps modulo 2^ptr_w).
  function automatic logic [31:0] ptr_diff(input logic [31:0] wptr,
                                           input logic [31:0] rptr,
                                           input int unsigned ptr_w);
    logic [31:0] mask;
    mask = (32'd1 << ptr_w) - 32'd1;
    return (wptr - rptr) & mask;
  endfunction

endpackage

// File: rtl/ram.sv
// Multi-port flip-flop RAM; rw_=1 reads, rw_=0 writes.
// OUTREG selects combinational or registered read data.
module ram #(
  parameter int DATA   = 16,
  parameter int DEPTH  = 8,
  parameter int PORT   = 2,
  parameter bit OUTREG = 1'b0,
  localparam int ADDR  = $clog2(DEPTH)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [PORT-1:0]             en,
  input  logic [PORT-1:0]             rw_,
  input  logic [PORT-1:0][ADDR-1:0]   addr,
  input  logic [PORT-1:0][DATA-1:0]   wdata,
  output logic [PORT-1:0][DATA-1:0]   rdata
);

  logic [DATA-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
    end else begin
      for (int p = 0; p < PORT; p++) begin
        if (en[p] && !rw_[p]) mem[addr[p]] <= wdata[p];
      end
    end
  end

  for (genvar p = 0; p < PORT; p++) begin : g_rd
    logic [DATA-1:0] rd_q;
    if (OUTREG) begin : g_reg
      always_ff @(posedge clk) begin
        if (reset) rd_q <= '0;
        else if (en[p] && rw_[p]) rd_q <= mem[addr[p]];
      end
    end else begin : g_comb
      assign rd_q = mem[addr[p]];
    end
    assign rdata[p] = rd_q;
  end

endmodule

// File: rtl/ram_fifo.sv
// Valid/ready FIFO on a 2-port flip-flop RAM (port 0 write, port 1 read), with a
// 2-entry skid buffer hiding RAM read latency so out_valid/out_data are registered.
module ram_fifo
  import ram_fifo_pkg::*;
#(
  parameter int DATA   = 16,
  parameter int DEPTH  = 8,
  parameter bit OUTREG = `DISABLE,
  localparam int ADDR  = $clog2(DEPTH),
  localparam int CNTW  = $clog2(DEPTH + 3)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DATA-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DATA-1:0] out_data,
  output logic [CNTW-1:0] count,
  output logic            full,
  output logic            empty
);

  localparam logic [ADDR:0]   PTR_ONE = (ADDR + 1)'(1);
  localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);

  logic [ADDR:0]             wptr, rptr;
  logic [31:0]               ram_occ;
  logic                      wr_fire, out_fire, skid_load;
  logic                      rd_issue_p0, vld_p1;
  logic [2:0]                slots_used;
  logic [1:0]                skid_cnt, skid_cnt_n;
  logic [DATA-1:0]           skid_q [SKID_DEPTH];
  logic [DATA-1:0]           skid_n [SKID_DEPTH];
  logic [DATA-1:0]           rd_data;
  logic [1:0]                ram_en, ram_rw_;
  logic [1:0][ADDR-1:0]      ram_addr;
  logic [1:0][DATA-1:0]      ram_wdata, ram_rdata;
  logic                      unused_rdata0;

  assign ram_occ  = ptr_diff(32'(wptr), 32'(rptr), ADDR + 1);
  assign in_ready = (ram_occ != 32'(DEPTH));
  assign full     = ~in_ready;
  assign empty    = (count == '0);
  assign wr_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // Stage p0: read issue. Reserve a skid slot for every read not yet landed.
  assign slots_used  = {1'b0, skid_cnt} + {2'b0, vld_p1} - {2'b0, out_fire};
  assign rd_issue_p0 = (ram_occ != 32'd0) && (slots_used < 3'(SKID_DEPTH));

  assign ram_en       = {rd_issue_p0, wr_fire};
  assign ram_rw_      = 2'b10;
  assign ram_addr[0]  = wptr[ADDR-1:0];
  assign ram_addr[1]  = rptr[ADDR-1:0];
  assign ram_wdata[0] = in_data;
  assign ram_wdata[1] = '0;
  assign rd_data      = ram_rdata[1];
  assign unused_rdata0 = ^ram_rdata[0];

  ram #(
    .DATA   (DATA),
    .DEPTH  (DEPTH),
    .PORT   (2),
    .OUTREG (OUTREG)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .en    (ram_en),
    .rw_   (ram_rw_),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr   <= '0;
      rptr   <= '0;
      vld_p1 <= 1'b0;
      count  <= '0;
    end else begin
      if (wr_fire)     wptr <= wptr + PTR_ONE;
      if (rd_issue_p0) rptr <= rptr + PTR_ONE;
      vld_p1 <= OUTREG && rd_issue_p0;
      case ({wr_fire, out_fire})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Stage p1: RAM data lands in the skid buffer (same cycle as issue when unregistered).
  assign skid_load = OUTREG ? vld_p1 : rd_issue_p0;

  always_comb begin
    skid_n     = skid_q;
    skid_cnt_n = skid_cnt;
    if (out_fire) begin
      skid_n[0]  = skid_q[1];
      skid_cnt_n = skid_cnt - 2'd1;
    end
    if (skid_load) begin
      skid_n[skid_cnt_n[0]] = rd_data;
      skid_cnt_n            = skid_cnt_n + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      skid_cnt  <= '0;
      skid_q[0] <= '0;
      skid_q[1] <= '0;
    end else begin
      skid_cnt <= skid_cnt_n;
      skid_q   <= skid_n;
    end
  end

  assign out_valid = (skid_cnt != 2'd0);
  assign out_data  = skid_q[0];

endmodule
